// File: rtl/tlk2711_pkg.sv
// Shared types and constants for the TLK2711 TX test-pattern path
// (frame scheduler on the TX side, pattern checker on the RX side).
package tlk2711_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    SEND = 3'd2,
    GAP  = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic [2:0]  MODE_LONG   = 3'd3;
  localparam logic [15:0] LONG_WORDS  = 16'd5376;
  localparam logic [15:0] SHORT_WORDS = 16'd435;
  localparam logic [15:0] PAT_INIT    = 16'h0001;
  localparam logic [7:0]  PAT_INCR    = 8'h02;

  // Each byte steps independently; no carry crosses from the low byte to the high byte.
  function automatic logic [15:0] next_pattern(input logic [15:0] p);
    logic [7:0] hi;
    logic [7:0] lo;
    hi = p[15:8] + PAT_INCR;
    lo = p[7:0] + PAT_INCR;
    return {hi, lo};
  endfunction

  function automatic logic [15:0] frame_words(input logic [2:0] mode);
    return (mode == MODE_LONG) ? LONG_WORDS : SHORT_WORDS;
  endfunction

endpackage

// File: rtl/tlk2711_pattern_gen.sv
// Byte-wise +2 test pattern register with init / advance / hold control.
// Shared between the TX scheduler and the RX validation checker.
module tlk2711_pattern_gen
  import tlk2711_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        init,
  input  logic        advance,
  output logic [15:0] pattern
);

  always_ff @(posedge clk) begin
    if (rst || init) begin
      pattern <= PAT_INIT;
    end else if (advance) begin
      pattern <= next_pattern(pattern);
    end
  end

endmodule

// File: rtl/tlk2711_tx_pattern_sched.sv
// Test-mode TX frame scheduler: writes a run of fixed-length pattern frames into
// the TX FIFO, separated by a programmable gap, and frames the run for the checker.
module tlk2711_tx_pattern_sched
  import tlk2711_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_soft_rst,
  input  logic        i_tx_start,
  input  logic        i_stop_req,
  input  logic [2:0]  i_tx_mode,
  input  logic [15:0] i_frame_num,
  input  logic [15:0] i_gap_cycles,
  input  logic        i_fifo_afull,
  output logic        o_valid,
  output logic [15:0] o_data,
  output logic        o_sof,
  output logic        o_eof,
  output logic        o_check_ena,
  output logic        o_tx_stop,
  output logic        o_busy,
  output logic [15:0] o_frame_cnt
);

  state_t      state;
  state_t      next_state;
  logic        clear;
  logic        start_q;
  logic        start_p;
  logic        load_run;
  logic        stop_pend;
  logic        stop_eff;
  logic        issue;
  logic        last_word;
  logic        run_done;
  logic [15:0] frame_len;
  logic [15:0] frame_num;
  logic [15:0] gap_len;
  logic [15:0] word_cnt;
  logic [15:0] gap_cnt;
  logic [15:0] pattern;
  logic        valid_d;
  logic        sof_d;
  logic        eof_d;
  logic        busy_d;
  logic        stop_d;

  assign clear     = rst | i_soft_rst;
  assign start_p   = i_tx_start & ~start_q;
  assign load_run  = (state == IDLE) & start_p;
  assign stop_eff  = stop_pend | i_stop_req;
  assign issue     = (state == SEND) & ~i_fifo_afull;
  assign last_word = issue & (word_cnt == frame_len - 16'd1);
  assign run_done  = stop_eff | ((frame_num != 16'd0) & ((o_frame_cnt + 16'd1) == frame_num));

  // Not reset, so a start level held across a reset does not look like a fresh edge.
  always_ff @(posedge clk) begin
    start_q <= i_tx_start;
  end

  tlk2711_pattern_gen u_pattern_gen (
    .clk     (clk),
    .rst     (clear),
    .init    (load_run),
    .advance (issue),
    .pattern (pattern)
  );

  always_ff @(posedge clk) begin
    if (clear) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start_p) next_state = LOAD;
      end
      LOAD: begin
        next_state = stop_eff ? DONE : SEND;
      end
      SEND: begin
        if (last_word) begin
          if (run_done)                next_state = DONE;
          else if (gap_len != 16'd0)   next_state = GAP;
          else                         next_state = SEND;
        end
      end
      GAP: begin
        if (stop_eff)                  next_state = DONE;
        else if (gap_cnt <= 16'd1)     next_state = SEND;
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // All outputs are a registered view of the cycle in which the FSM acted.
  always_comb begin
    valid_d = issue;
    sof_d   = issue & (word_cnt == 16'd0);
    eof_d   = last_word;
    busy_d  = (state != IDLE);
    stop_d  = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      o_valid     <= 1'b0;
      o_sof       <= 1'b0;
      o_eof       <= 1'b0;
      o_check_ena <= 1'b0;
      o_tx_stop   <= 1'b0;
      o_busy      <= 1'b0;
      o_data      <= PAT_INIT;
      o_frame_cnt <= 16'd0;
      word_cnt    <= 16'd0;
      gap_cnt     <= 16'd0;
      stop_pend   <= 1'b0;
      frame_len   <= SHORT_WORDS;
      frame_num   <= 16'd0;
      gap_len     <= 16'd0;
    end else begin
      o_valid     <= valid_d;
      o_sof       <= sof_d;
      o_eof       <= eof_d;
      o_check_ena <= busy_d;
      o_tx_stop   <= stop_d;
      o_busy      <= busy_d;

      if (issue) begin
        o_data   <= pattern;
        word_cnt <= last_word ? 16'd0 : word_cnt + 16'd1;
      end

      if (last_word) begin
        o_frame_cnt <= o_frame_cnt + 16'd1;
      end

      if (load_run) begin
        frame_len   <= frame_words(i_tx_mode);
        frame_num   <= i_frame_num;
        gap_len     <= i_gap_cycles;
        o_frame_cnt <= 16'd0;
        word_cnt    <= 16'd0;
      end

      if ((state != GAP) && (next_state == GAP)) begin
        gap_cnt <= gap_len;
      end else if (state == GAP) begin
        gap_cnt <= gap_cnt - 16'd1;
      end

      if (next_state == IDLE) begin
        stop_pend <= 1'b0;
      end else if ((state != IDLE) && i_stop_req) begin
        stop_pend <= 1'b1;
      end
    end
  end

endmodule

// File: doc/tlk2711_tx_pattern_sched.md
Name: tlk2711_tx_pattern_sched

Overview:
Test-mode TX frame scheduler for the TLK2711 link. On a start request it writes a run of fixed-length frames into the TX FIFO, separated by a programmable inter-frame gap. Each frame carries the incrementing 16-bit pattern that the TX validation checker expects. The block sits between the register/control interface and the TX FIFO write port, and drives the checker's enable and stop strobes.

Parameters:
- MODE_LONG, 3'd3, value of i_tx_mode that selects long frames
- LONG_WORDS, 16'd5376, words per frame when i_tx_mode == MODE_LONG (10752 bytes)
- SHORT_WORDS, 16'd435, words per frame in all other modes (870 bytes)
- PAT_INIT, 16'h0001, first pattern word of a run

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- i_soft_rst  in  1  synchronous soft reset; same effect as rst
- i_tx_start  in  1  level; its rising edge starts a run
- i_stop_req  in  1  level; ends the run at the next frame boundary
- i_tx_mode  in  3  frame-length select; sampled at the start edge
- i_frame_num  in  16  frames per run; 0 means continuous until stop
- i_gap_cycles  in  16  idle cycles between frames; sampled at the start edge
- i_fifo_afull  in  1  TX FIFO almost-full; stalls writes
- o_valid  out  1  FIFO write enable
- o_data  out  16  pattern word
- o_sof  out  1  high with the first word of a frame
- o_eof  out  1  high with the last word of a frame
- o_check_ena  out  1  checker enable; high for the whole run
- o_tx_stop  out  1  one-cycle pulse at the end of a run
- o_busy  out  1  high whenever the state is not IDLE
- o_frame_cnt  out  16  frames completed in the current or last run

Behaviour:
- Reset (rst or i_soft_rst): state=IDLE; o_valid, o_sof, o_eof, o_check_ena, o_tx_stop, o_busy = 0; o_data=PAT_INIT; o_frame_cnt=0.
- Start edge detect: start_p = i_tx_start & ~i_tx_start_q, using a registered copy of i_tx_start. Start edges are ignored unless state is IDLE.
- IDLE -> LOAD on start_p:
  - latch frame length (LONG_WORDS or SHORT_WORDS), i_frame_num and i_gap_cycles;
  - o_frame_cnt=0; pattern=PAT_INIT;
  - o_check_ena=1 from the LOAD cycle onward.
- LOAD -> SEND after one cycle. This gives the checker one cycle of enable before the first valid word.
- SEND:
  - each cycle with i_fifo_afull==0: o_valid=1, o_data=pattern, word_cnt++;
  - pattern high and low bytes each add 8'h02, modulo 256 per byte, with no carry between bytes. Sequence: 0001, 0203, 0405, …, FEFF, 0001.
  - o_sof=1 when word_cnt==0; o_eof=1 when word_cnt==len-1.
  - i_fifo_afull==1: o_valid=0; pattern and counters hold. This applies on any word, including the sof and eof words.
- End of frame (the cycle carrying o_eof): word_cnt=0 and o_frame_cnt++. Then:
  - if stop is pending, or (i_frame_num!=0 and o_frame_cnt+1==i_frame_num): go to DONE;
  - else if gap==0: stay in SEND, so the next frame starts on the following cycle;
  - else: go to GAP.
- Pattern continuity: the pattern is not reset between frames; it runs continuously through the whole run.
- GAP: count down gap cycles with o_valid=0, then return to SEND.
- Stop pending: a flag set by i_stop_req high in any non-IDLE state. It is cleared on entry to IDLE.
  - A stop request seen during GAP or LOAD goes straight to DONE. A partial frame is never emitted.
- DONE: o_tx_stop=1 for exactly one cycle; o_check_ena drops the next cycle; next state is IDLE.
  - The checker resets its expected pattern on this o_tx_stop pulse.
- A new start edge arriving while busy is dropped, not queued.
- Reset mid-run: all outputs return to reset values the next cycle. No o_tx_stop is issued.
- Outputs are registered. First word latency is 2 cycles after the start edge is sampled: LOAD, then SEND.

Decomposition:
- Shared package tlk2711_pkg holds:
  - state encoding enum (IDLE, LOAD, SEND, GAP, DONE);
  - frame-length constants 5376 and 435;
  - MODE_LONG;
  - pattern increment 8'h02.
- One natural sub-module: tlk2711_pattern_gen. It provides the byte-wise +2 pattern register with init, advance and hold controls, and is reusable by the RX checker.

Test Plan:
- Mode 0, frame_num=2, gap=4, no afull:
  - 870 valid words with o_sof at words 0 and 435, o_eof at words 434 and 869;
  - 4 idle cycles between the frames;
  - o_frame_cnt=2, then a single o_tx_stop pulse.
- Mode 3, frame_num=1: 5376 words; pattern wraps 0xFEFF->0x0001 every 128 words; last word = 0xFEFF.
- i_fifo_afull toggled every 3 cycles during SEND:
  - no word is lost or duplicated;
  - the pattern sequence matches the stall-free run exactly;
  - the frame is still 435 valid words.
- frame_num=0, stop_req asserted mid-frame 3: frame 3 completes in full; o_frame_cnt=3; o_tx_stop pulses; o_busy falls the next cycle.
- Second i_tx_start edge during SEND is ignored; soft reset mid-frame gives o_valid=0, o_data=0x0001, o_frame_cnt=0 and no o_tx_stop.
- Back-to-back runs: the second run starts again at pattern 0x0001.
